wb_reg_file: RTL

- Register file sitting at the receiving end of the writeback path: it consumes the write-back value, write index and write enable produced by the WB stage.
- Serves two combinational read ports to the ID stage.
- Adds write-to-read bypass so an ID read in the same cycle as a WB write sees the new value.
- Keeps a per-register pending scoreboard so ID can stall on an outstanding load destination.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/wb_reg_file.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipeline stages (ID, EX, WB) and the register
// file: architectural widths, the hard-wired zero register index and the
// common word / register-index types.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
    localparam int NUM_REGS = 1 << IDX_W;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // r0 is hard-wired to zero: never written, never pending.
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per architectural register, set when ID issues a load and
// cleared when WB writes the destination back. Produces the ID stall request.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pend_set, pend_idx    mark pend_idx as waiting on a load
//   wb_we, wb_idx         write-back completing this cycle
//   rs_idx, rt_idx        ID read indices
//   stall                 an ID read index is still waiting on a load
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int IDX_W    = mips_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pend_set,
    input  logic [IDX_W-1:0] pend_idx,
    input  logic             wb_we,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [IDX_W-1:0] rs_idx,
    input  logic [IDX_W-1:0] rt_idx,
    output logic             stall
);
    import mips_pkg::*;

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending;
    logic                rs_busy;
    logic                rt_busy;

    // The set is applied after the clear so that, on the same index, the
    // younger load issued by ID keeps the register pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wb_we) begin
                pending[wb_idx] <= 1'b0;
            end
            if (pend_set && (pend_idx != ZERO_IDX)) begin
                pending[pend_idx] <= 1'b1;
            end
        end
    end

    // A write-back landing this cycle is bypassed to ID, so it releases the
    // stall immediately instead of one cycle later.
    always_comb begin
        rs_busy = (rs_idx != ZERO_IDX) && pending[rs_idx] && !(wb_we && (wb_idx == rs_idx));
        rt_busy = (rt_idx != ZERO_IDX) && pending[rt_idx] && !(wb_we && (wb_idx == rt_idx));
        stall   = rs_busy || rt_busy;
    end

endmodule

// File: rtl/wb_reg_file.sv
// ---------------------------------------------------------------------------
// wb_reg_file
// Architectural register file at the end of the writeback path. Two
// combinational read ports for ID with write-to-read bypass, one write port
// from WB, and a load scoreboard that asks ID to stall.
// Interface: plain enables, no valid/ready. A write (wb_we) or a pending mark
// (pend_set) is taken on every rising edge where it is high; neither can be
// back-pressured.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_we, wb_idx, wb_data     write-back from WB
//   rs_idx, rs_data            read port A
//   rt_idx, rt_data            read port B
//   pend_set, pend_idx         ID issues a load to pend_idx
//   stall                      rs_idx or rt_idx waits on a load
// IDX_W must equal log2(NUM_REGS).
// ---------------------------------------------------------------------------
module wb_reg_file #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int IDX_W    = mips_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [IDX_W-1:0]  rs_idx,
    input  logic [IDX_W-1:0]  rt_idx,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              pend_set,
    input  logic [IDX_W-1:0]  pend_idx,
    output logic              stall
);
    import mips_pkg::*;

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Entry 0 is never written, so it stays at its reset value of zero; the
    // read muxes still force zero for index 0 independently of storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_idx != ZERO_IDX)) begin
            regs[wb_idx] <= wb_data;
        end
    end

    // Read priority: zero register, then same-cycle write-back, then storage.
    always_comb begin
        rs_data = '0;
        if (rs_idx != ZERO_IDX) begin
            if (wb_we && (wb_idx == rs_idx)) begin
                rs_data = wb_data;
            end else begin
                rs_data = regs[rs_idx];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_idx != ZERO_IDX) begin
            if (wb_we && (wb_idx == rt_idx)) begin
                rt_data = wb_data;
            end else begin
                rt_data = regs[rt_idx];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .pend_set (pend_set),
        .pend_idx (pend_idx),
        .wb_we    (wb_we),
        .wb_idx   (wb_idx),
        .rs_idx   (rs_idx),
        .rt_idx   (rt_idx),
        .stall    (stall)
    );

endmodule
